// File: rtl/id_stage.sv
// id_stage: instruction decode with a 32x32 write-first register file and a registered
// execute bundle. Defining ID_HAZARD_DETECT_EN enables load-use stall insertion.
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs,
    output logic [XLEN-1:0] rt,
    output logic [XLEN-1:0] sign_ext,
    output logic            ALUSrc,
    output logic [1:0]      ALUOp,
    output logic            branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic [4:0]      dest_reg,
    output logic [XLEN-1:0] pc,
    output logic            stall_flag
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_ADDI  = 6'b001000,
        OP_BEQ   = 6'b000100
    } opcode_e;

    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_ext;

    logic            dec_alusrc;
    logic [1:0]      dec_aluop;
    logic            dec_branch;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_reg_write;
    logic [4:0]      dec_dest;
    logic            hazard;

    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign imm_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Same-cycle write-back wins over the stored value so decode never sees stale data.
    always_comb begin
        rs_val = '0;
        if (rs_addr != 5'd0) begin
            rs_val = (wb_en && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
        end
    end

    always_comb begin
        rt_val = '0;
        if (rt_addr != 5'd0) begin
            rt_val = (wb_en && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
        end
    end

    always_comb begin
        dec_alusrc    = 1'b0;
        dec_aluop     = 2'b00;
        dec_branch    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_dest      = 5'd0;
        if (instr_valid) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    dec_aluop     = 2'b10;
                    dec_reg_write = 1'b1;
                    dec_dest      = instr[15:11];
                end
                OP_LW: begin
                    dec_alusrc    = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_dest      = rt_addr;
                end
                OP_SW: begin
                    dec_alusrc    = 1'b1;
                    dec_mem_write = 1'b1;
                end
                OP_ADDI: begin
                    dec_alusrc    = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_dest      = rt_addr;
                end
                OP_BEQ: begin
                    dec_aluop     = 2'b01;
                    dec_branch    = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ID_HAZARD_DETECT_EN
    logic known_op;
    logic reads_rt;

    // The output register holds the previous instruction; a load there feeding us forces one bubble.
    always_comb begin
        known_op = 1'b0;
        reads_rt = 1'b0;
        case (instr[31:26])
            OP_RTYPE, OP_SW, OP_BEQ: begin
                known_op = 1'b1;
                reads_rt = 1'b1;
            end
            OP_LW, OP_ADDI: known_op = 1'b1;
            default: ;
        endcase
        hazard = instr_valid && known_op && mem_read && (dest_reg != 5'd0) &&
                 ((dest_reg == rs_addr) || (reads_rt && (dest_reg == rt_addr)));
    end
`else
    assign hazard = 1'b0;
`endif

    assign instr_ready = ~hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs         <= '0;
            rt         <= '0;
            sign_ext   <= '0;
            pc         <= '0;
            ALUSrc     <= 1'b0;
            ALUOp      <= 2'b00;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            dest_reg   <= 5'd0;
            stall_flag <= 1'b0;
        end else begin
            rs         <= rs_val;
            rt         <= rt_val;
            sign_ext   <= imm_ext;
            pc         <= pc_in;
            ALUSrc     <= hazard ? 1'b0  : dec_alusrc;
            ALUOp      <= hazard ? 2'b00 : dec_aluop;
            branch     <= hazard ? 1'b0  : dec_branch;
            mem_read   <= hazard ? 1'b0  : dec_mem_read;
            mem_write  <= hazard ? 1'b0  : dec_mem_write;
            reg_write  <= hazard ? 1'b0  : dec_reg_write;
            dest_reg   <= hazard ? 5'd0  : dec_dest;
            stall_flag <= hazard;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed checks of id_stage against an instruction-level
// reference model (register array plus per-opcode control table).
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs, rt, sign_ext, pc;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic        branch, mem_read, mem_write, reg_write, stall_flag;
    logic [4:0]  dest_reg;

    int vectors     = 0;
    int miscompares = 0;
    logic check_en  = 1'b0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs(rs), .rt(rt), .sign_ext(sign_ext), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .dest_reg(dest_reg), .pc(pc), .stall_flag(stall_flag)
    );

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] sext;
        logic        alusrc;
        logic [1:0]  aluop;
        logic        branch;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        stall;
    } bundle_t;

    bundle_t     exp_b;
    logic [31:0] mregs [32];

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    // Stall when the previously accepted instruction was a load whose target this one needs.
    function automatic logic model_hazard();
`ifdef ID_HAZARD_DETECT_EN
        logic [5:0] op = instr[31:26];
        logic known = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h08) || (op == 6'h04);
        logic uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return instr_valid && known && exp_b.mr && (exp_b.dest != 5'd0) &&
               ((exp_b.dest == instr[25:21]) || (uses_rt && exp_b.dest == instr[20:16]));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bundle_t model_decode();
        bundle_t b = '0;
        b.rs   = model_read(instr[25:21]);
        b.rt   = model_read(instr[20:16]);
        b.sext = {{16{instr[15]}}, instr[15:0]};
        b.pc   = pc_in;
        if (model_hazard()) begin
            b.stall = 1'b1;
            return b;
        end
        if (!instr_valid) return b;
        case (instr[31:26])
            6'h00: begin b.aluop = 2'b10; b.rw = 1'b1; b.dest = instr[15:11]; end
            6'h23: begin b.alusrc = 1'b1; b.mr = 1'b1; b.rw = 1'b1; b.dest = instr[20:16]; end
            6'h2B: begin b.alusrc = 1'b1; b.mw = 1'b1; end
            6'h08: begin b.alusrc = 1'b1; b.rw = 1'b1; b.dest = instr[20:16]; end
            6'h04: begin b.aluop = 2'b01; b.branch = 1'b1; end
            default: ;
        endcase
        return b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_b <= '0;
            for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
        end else begin
            exp_b <= model_decode();
            if (wb_en && wb_addr != 5'd0) mregs[wb_addr] <= wb_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && reset) begin
            checkOutput("rs", rs, exp_b.rs);
            checkOutput("rt", rt, exp_b.rt);
            checkOutput("sign_ext", sign_ext, exp_b.sext);
            checkOutput("pc", pc, exp_b.pc);
            checkOutput("ALUSrc", 32'(ALUSrc), 32'(exp_b.alusrc));
            checkOutput("ALUOp", 32'(ALUOp), 32'(exp_b.aluop));
            checkOutput("branch", 32'(branch), 32'(exp_b.branch));
            checkOutput("mem_read", 32'(mem_read), 32'(exp_b.mr));
            checkOutput("mem_write", 32'(mem_write), 32'(exp_b.mw));
            checkOutput("reg_write", 32'(reg_write), 32'(exp_b.rw));
            checkOutput("dest_reg", 32'(dest_reg), 32'(exp_b.dest));
            checkOutput("stall_flag", 32'(stall_flag), 32'(exp_b.stall));
            checkOutput("instr_ready", 32'(instr_ready), 32'(!model_hazard()));
        end
    end

    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input logic v,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr = i; pc_in = p; instr_valid = v;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_rs"}, rs, 32'd0);
        checkOutput({tag, "_sext"}, sign_ext, 32'd0);
        checkOutput({tag, "_pc"}, pc, 32'd0);
        checkOutput({tag, "_ctrl"}, {25'd0, ALUSrc, ALUOp, branch, mem_read, mem_write, reg_write},
                    32'd0);
        checkOutput({tag, "_dest"}, 32'(dest_reg), 32'd0);
        checkOutput({tag, "_stall"}, 32'(stall_flag), 32'd0);
        checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] s,
                                          input logic [4:0] t, input logic [5:0] f);
        return {6'h00, s, t, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    initial begin
        logic        hold;
        logic [5:0]  ops [7];
        logic [31:0] ri;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h3F, 6'h11};

        reset = 1'b0;
        applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        checkZeroOutputs("por");
        #11 reset = 1'b1;
        check_en = 1'b1;
        tick();

        applyStimulus(32'd0, 32'h100, 1'b0, 1'b1, 5'd3, 32'h0000_00AA);
        tick();
        applyStimulus(rtype(5'd1, 5'd3, 5'd3, 6'd0), 32'h104, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("add_rs", rs, 32'hAA);
        checkOutput("add_rt", rt, 32'hAA);
        checkOutput("add_aluop", 32'(ALUOp), 32'd2);
        checkOutput("add_funct", 32'(sign_ext[5:0]), 32'd0);
        checkOutput("add_dest", 32'(dest_reg), 32'd1);

        applyStimulus(itype(6'h08, 5'd4, 5'd2, 16'hFFFF), 32'h108, 1'b1, 1'b1, 5'd4, 32'h1234);
        tick();
        checkOutput("byp_rs", rs, 32'h1234);
        checkOutput("byp_sext", sign_ext, 32'hFFFF_FFFF);
        checkOutput("byp_alusrc", 32'(ALUSrc), 32'd1);

        applyStimulus(32'd0, 32'h10C, 1'b0, 1'b1, 5'd0, 32'h55);
        tick();
        applyStimulus(rtype(5'd1, 5'd0, 5'd0, 6'd1), 32'h110, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("r0_rs", rs, 32'd0);
        checkOutput("r0_rt", rt, 32'd0);

        applyStimulus(itype(6'h23, 5'd1, 5'd6, 16'd4), 32'h114, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("lw_memread", 32'(mem_read), 32'd1);
        checkOutput("lw_dest", 32'(dest_reg), 32'd6);
        applyStimulus(rtype(5'd7, 5'd6, 5'd2, 6'd0), 32'h118, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
`ifdef ID_HAZARD_DETECT_EN
        checkOutput("lu_ready", 32'(instr_ready), 32'd0);
        tick();
        checkOutput("lu_stall", 32'(stall_flag), 32'd1);
        checkOutput("lu_rw", 32'(reg_write), 32'd0);
        checkOutput("lu_dest", 32'(dest_reg), 32'd0);
        checkOutput("lu_ready2", 32'(instr_ready), 32'd1);
        tick();
`else
        checkOutput("lu_ready", 32'(instr_ready), 32'd1);
        tick();
`endif
        checkOutput("lu_add_stall", 32'(stall_flag), 32'd0);
        checkOutput("lu_add_dest", 32'(dest_reg), 32'd7);
        checkOutput("lu_add_rw", 32'(reg_write), 32'd1);

        applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'd8), 32'h11C, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("beq_ctrl", {25'd0, ALUSrc, ALUOp, branch, mem_read, mem_write, reg_write},
                    32'b0_01_1_0_0_0);
        checkOutput("beq_sext", sign_ext, 32'd8);

        applyStimulus({6'h3F, 26'h0123456}, 32'h120, 1'b1, 1'b1, 5'd5, 32'h77);
        tick();
        checkOutput("unk_ctrl", {20'd0, ALUSrc, ALUOp, branch, mem_read, mem_write, reg_write,
                    dest_reg}, 32'd0);
        checkOutput("unk_stall", 32'(stall_flag), 32'd0);

        applyStimulus(rtype(5'd1, 5'd5, 5'd5, 6'd2), 32'h124, 1'b1, 1'b0, 5'd0, 32'd0);
        #1 reset = 1'b0;
        #1;
        checkZeroOutputs("mid");
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        checkOutput("r5_after_rst", rs, 32'd0);
        checkOutput("r5_dest", 32'(dest_reg), 32'd1);

        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (hold) begin
                ri = instr;
            end else begin
                ri = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 2))};
            end
            applyStimulus(ri, hold ? pc_in : $urandom, hold ? 1'b1 : ($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            hold = model_hazard();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
